// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-side stage behind the multi-cycle controller. Each ce strobe accepted
//   in IDLE becomes one request/grant/response transaction on a single-port bus.
//   The stage steers RV32 byte/half/word lanes, sign- or zero-extends loads, and
//   holds the instruction register (ir) and memory data register (mdr).
//
//   Optional build macro: MEM_ACC_MISALIGN_TRAP_EN
//     defined   : adds port misalign; misaligned accesses complete without a bus
//                 transaction and flag misalign together with done.
//     undefined : offset bits below natural alignment are ignored.
//
//   Ports
//     clk, rst                  clock, async active-high reset
//     ce, wre, ior_d_sel        access strobe, store select, fetch/data select
//     ir_write_en, funct3       IR capture enable, access width/sign
//     pc, alu_result            fetch address, data address
//     store_data                store operand (rs2)
//     busy, done                handshake back to the controller
//     ir, mdr                   instruction register, extended load data
//     mem_req/we/addr/be/wdata  bus request side
//     mem_gnt, mem_rvalid,
//     mem_rdata                 bus grant and response
//
//   State | meaning
//   IDLE  | waiting for ce; inputs latched on accept
//   REQ   | mem_req high, bus fields stable until mem_gnt
//   RESP  | waiting for mem_rvalid (loads and fetches only)
//   DONE  | one-cycle done pulse; ce ignored
module mem_access_unit #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            wre,
    input  logic            ior_d_sel,
    input  logic            ir_write_en,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    output logic            busy,
    output logic            done,
`ifdef MEM_ACC_MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] mdr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    // Store encodings only know SB/SH; 100/101 are byte/half for loads only.
    function automatic logic [1:0] width_of(input logic [2:0] f3, input logic is_store);
        logic [1:0] w;
        w = W_WORD;
        if (f3 == 3'b000 || (!is_store && f3 == 3'b100))
            w = W_BYTE;
        else if (f3 == 3'b001 || (!is_store && f3 == 3'b101))
            w = W_HALF;
        return w;
    endfunction

    state_t          state_q, state_d;
    kind_t           kind_q, kind_d;
    logic [2:0]      f3_q, f3_d;
    logic            irwe_q, irwe_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
`endif

    logic [XLEN-1:0] acc_addr;
    logic [1:0]      acc_off;
    logic            acc_fetch;
    logic            acc_store;
    logic [2:0]      acc_f3;
    logic [1:0]      acc_w;
    logic [3:0]      acc_be;
    logic [XLEN-1:0] acc_wdata;
    logic            acc_mis;

    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] load_ext;

    // Decode of the access presented in IDLE; only used on the accept edge.
    always_comb begin
        acc_addr  = ior_d_sel ? alu_result : pc;
        acc_off   = acc_addr[1:0];
        acc_fetch = ~ior_d_sel;
        acc_store = ior_d_sel & wre;
        acc_f3    = acc_fetch ? 3'b010 : funct3;
        acc_w     = width_of(acc_f3, acc_store);
        acc_be    = 4'b1111;
        acc_wdata = store_data;
        acc_mis   = 1'b0;
        case (acc_w)
            W_BYTE: begin
                acc_be    = 4'b0001 << acc_off;
                acc_wdata = {4{store_data[7:0]}};
            end
            W_HALF: begin
                acc_be    = acc_off[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
        if (!acc_store)
            acc_wdata = '0;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
        acc_mis = (acc_w == W_HALF && acc_off[0]) || (acc_w == W_WORD && acc_off != 2'b00);
`endif
    end

    // Lane selection and extension of returning load data.
    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (off_q)
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            2'd3:    rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'b0, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'b0, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        f3_d    = f3_q;
        irwe_d  = irwe_q;
        off_d   = off_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ce) begin
                    kind_d  = acc_fetch ? K_FETCH : (acc_store ? K_STORE : K_LOAD);
                    f3_d    = acc_f3;
                    irwe_d  = ir_write_en;
                    off_d   = acc_off;
                    addr_d  = {acc_addr[XLEN-1:2], 2'b00};
                    we_d    = acc_store;
                    be_d    = acc_be;
                    wdata_d = acc_wdata;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
                    mis_d   = acc_mis;
`endif
                    state_d = acc_mis ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt)
                    state_d = (kind_q == K_STORE) ? S_DONE : S_RESP;
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    if (kind_q == K_FETCH) begin
                        mdr_d = mem_rdata;
                        if (irwe_q)
                            ir_d = mem_rdata;
                    end else begin
                        mdr_d = load_ext;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef MEM_ACC_MISALIGN_TRAP_EN
                mis_d   = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= K_FETCH;
            f3_q    <= 3'b010;
            irwe_q  <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            ir_q    <= RESET_IR;
            mdr_q   <= '0;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            f3_q    <= f3_d;
            irwe_q  <= irwe_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Request and handshake decode straight from the state register so that
    // an asynchronous reset drops mem_req without waiting for a clock.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
    assign misalign  = mis_q && (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs driven and outputs sampled on the
// falling edge, design registers on the rising edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, wre, ior_d_sel, ir_write_en;
    logic [2:0]  funct3;
    logic [31:0] pc, alu_result, store_data;
    logic        busy, done;
    logic [31:0] ir, mdr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .ce(ce), .wre(wre), .ior_d_sel(ior_d_sel), .ir_write_en(ir_write_en),
        .funct3(funct3), .pc(pc), .alu_result(alu_result), .store_data(store_data),
        .busy(busy), .done(done),
`ifdef MEM_ACC_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .ir(ir), .mdr(mdr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ce = 0; wre = 0; ior_d_sel = 0; ir_write_en = 0; funct3 = 3'b000;
        pc = 0; alu_result = 0; store_data = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        nxt(); nxt();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_mdr", mdr, 32'd0);
        chk("rst_ir", ir, 32'h0000_0013);
        rst = 1'b0;

        // Fetch at 0x100 with IR write, zero-wait grant, rvalid next cycle.
        nxt();
        ce = 1; ior_d_sel = 0; pc = 32'h100; ir_write_en = 1; wre = 1; funct3 = 3'b111; mem_gnt = 1;
        nxt();
        ce = 0; pc = 32'hFFF0; mem_rdata = 32'hDEAD_BEEF;
        chk("f_req", {31'b0, mem_req}, 32'd1);
        chk("f_busy", {31'b0, busy}, 32'd1);
        chk("f_addr", mem_addr, 32'h100);
        chk("f_be", {28'b0, mem_be}, 32'hF);
        chk("f_we", {31'b0, mem_we}, 32'd0);
        nxt();
        chk("f_resp_req", {31'b0, mem_req}, 32'd0);
        chk("f_resp_done", {31'b0, done}, 32'd0);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00A0_0093;
        nxt();
        chk("f_done", {31'b0, done}, 32'd1);
        chk("f_ir", ir, 32'h00A0_0093);
        chk("f_mdr", mdr, 32'h00A0_0093);
        mem_rvalid = 0;
        nxt();
        chk("f_done_pulse", {31'b0, done}, 32'd0);
        chk("f_idle", {31'b0, busy}, 32'd0);

        // LB at 0x203: rvalid in grant cycle ignored, one wait cycle in RESP.
        ce = 1; ior_d_sel = 1; wre = 0; ir_write_en = 0; funct3 = 3'b000; alu_result = 32'h203; mem_gnt = 1;
        nxt();
        ce = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        chk("lb_addr", mem_addr, 32'h200);
        chk("lb_req", {31'b0, mem_req}, 32'd1);
        nxt();
        mem_gnt = 0; mem_rvalid = 0;
        chk("lb_resp_req", {31'b0, mem_req}, 32'd0);
        chk("lb_early_done", {31'b0, done}, 32'd0);
        nxt();
        chk("lb_wait_done", {31'b0, done}, 32'd0);
        chk("lb_wait_busy", {31'b0, busy}, 32'd1);
        mem_rvalid = 1; mem_rdata = 32'h80FF_FF7F;
        nxt();
        chk("lb_done", {31'b0, done}, 32'd1);
        chk("lb_mdr", mdr, 32'hFFFF_FF80);
        chk("lb_ir", ir, 32'h00A0_0093);
        mem_rvalid = 0;
        nxt();

        // LBU at 0x203.
        ce = 1; funct3 = 3'b100; mem_gnt = 1;
        nxt();
        ce = 0;
        nxt();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h80FF_FF7F;
        nxt();
        chk("lbu_done", {31'b0, done}, 32'd1);
        chk("lbu_mdr", mdr, 32'h0000_0080);
        mem_rvalid = 0;
        nxt();

        // LH at 0x302: upper half 0x8001 sign-extended.
        ce = 1; funct3 = 3'b001; alu_result = 32'h302; mem_gnt = 1;
        nxt();
        ce = 0;
        chk("lh_addr", mem_addr, 32'h300);
        nxt();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h8001_7FFF;
        nxt();
        chk("lh_mdr", mdr, 32'hFFFF_8001);
        mem_rvalid = 0;
        nxt();

        // SH at 0x402, grant delayed 3 cycles; inputs change while busy.
        ce = 1; wre = 1; funct3 = 3'b001; alu_result = 32'h402; store_data = 32'h1234_ABCD; mem_gnt = 0;
        nxt();
        ce = 0; alu_result = 32'h0; store_data = 32'h0; funct3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            chk("sh_req_held", {31'b0, mem_req}, 32'd1);
            chk("sh_addr", mem_addr, 32'h400);
            chk("sh_be", {28'b0, mem_be}, 32'hC);
            chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
            chk("sh_we", {31'b0, mem_we}, 32'd1);
            if (i == 3) mem_gnt = 1;
            nxt();
        end
        mem_gnt = 0;
        chk("sh_done", {31'b0, done}, 32'd1);
        chk("sh_req_drop", {31'b0, mem_req}, 32'd0);
        chk("sh_mdr", mdr, 32'hFFFF_8001);
        ce = 1;  // ce during DONE must be ignored
        nxt();
        chk("sh_ce_in_done", {31'b0, busy}, 32'd0);
        ce = 0;
        nxt();

        // SB at 0x101, zero-wait: done two edges after accept.
        ce = 1; wre = 1; funct3 = 3'b000; alu_result = 32'h101; store_data = 32'h0000_00A5; mem_gnt = 1;
        nxt();
        ce = 0;
        chk("sb_be", {28'b0, mem_be}, 32'h2);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sb_req", {31'b0, mem_req}, 32'd1);
        nxt();
        mem_gnt = 0;
        chk("sb_done", {31'b0, done}, 32'd1);
        nxt();

        // Reset while in RESP, then a late rvalid.
        ce = 1; ior_d_sel = 0; wre = 0; pc = 32'h500; ir_write_en = 1; mem_gnt = 1;
        nxt();
        ce = 0;
        nxt();
        mem_gnt = 0;
        chk("r_in_resp", {31'b0, busy}, 32'd1);
        rst = 1;
        #1;
        chk("r_req", {31'b0, mem_req}, 32'd0);
        chk("r_ir", ir, 32'h0000_0013);
        chk("r_mdr", mdr, 32'd0);
        nxt();
        rst = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("r_no_done", {31'b0, done}, 32'd0);
            chk("r_ir_kept", ir, 32'h0000_0013);
            chk("r_mdr_kept", mdr, 32'd0);
        end
        mem_rvalid = 0;

        // Misaligned LW at 0x301.
        ce = 1; ior_d_sel = 1; wre = 0; funct3 = 3'b010; alu_result = 32'h301; ir_write_en = 0; mem_gnt = 1;
        nxt();
        ce = 0;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
        chk("mis_req", {31'b0, mem_req}, 32'd0);
        chk("mis_done", {31'b0, done}, 32'd1);
        chk("mis_flag", {31'b0, misalign}, 32'd1);
        chk("mis_mdr", mdr, 32'd0);
        mem_gnt = 0;
        nxt();
        chk("mis_flag_clr", {31'b0, misalign}, 32'd0);
        chk("mis_done_clr", {31'b0, done}, 32'd0);
`else
        chk("lw_addr", mem_addr, 32'h300);
        chk("lw_req", {31'b0, mem_req}, 32'd1);
        nxt();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        nxt();
        chk("lw_done", {31'b0, done}, 32'd1);
        chk("lw_mdr", mdr, 32'hCAFE_F00D);
        chk("lw_ir", ir, 32'h0000_0013);
        mem_rvalid = 0;
        nxt();
`endif
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-side stage directly downstream of the multi-cycle controller. It consumes the controller's memory strobes (ce, wre, IorD select, IR write enable) and turns each strobe into one request/grant/response transaction on a single-port memory bus. It performs RV32 byte/half/word lane steering with load sign/zero extension, and holds the instruction register (IR) and memory data register (MDR). A busy/done handshake lets the controller hold its state while memory wait states elapse.

Parameters:
XLEN, 32, data and address width; only 32 is supported.
RESET_IR, 32'h0000_0013, IR value after reset (NOP).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ce  in  1  access strobe from controller (level)
wre  in  1  1 = store, 0 = load/fetch
ior_d_sel  in  1  0 = fetch at pc, 1 = data access at alu_result
ir_write_en  in  1  capture read data into IR
funct3  in  3  instruction width/sign field
pc  in  32  fetch address
alu_result  in  32  data address
store_data  in  32  rs2 value for stores
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
ir  out  32  instruction register
mdr  out  32  load data, extended
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  32  word-aligned bus address
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated write data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Reset values: state IDLE; busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, mdr=0, ir=RESET_IR. Reset mid-transaction drops mem_req immediately and abandons the transaction. A late mem_rvalid after reset is ignored.
- States:
  - IDLE: ce=1 latches the following, then goes to REQ: addr = ior_d_sel ? alu_result : pc; kind = fetch / load / store (fetch when ior_d_sel=0, which forces word width and ignores wre and funct3); funct3; ir_write_en; store_data.
  - REQ: mem_req=1 with mem_we, mem_addr, mem_be and mem_wdata held stable until sampled with mem_gnt=1.
    - Store: a grant goes to DONE.
    - Load or fetch: a grant goes to RESP.
  - RESP: mem_req=0. Waits for mem_rvalid; on it, captures data and goes to DONE. mem_rvalid in the grant cycle itself is not valid; the earliest response is the cycle after the grant.
  - DONE: done=1 for exactly one cycle, then IDLE. ce is ignored in DONE. A new access needs ce in IDLE.
- busy = (state != IDLE).
- Minimum latency from ce sampled to done high: 2 cycles for a store (zero-wait grant), 3 cycles for a read.
- mem_addr = {addr[31:2], 2'b00}. off = addr[1:0].
- Stores:
  - SB (funct3 000): be = 4'b0001 << off; wdata = {4{sd[7:0]}}.
  - SH (001): be = off[1] ? 4'b1100 : 4'b0011; wdata = {2{sd[15:0]}}.
  - SW (010, and any other funct3): be = 4'b1111.
- Loads: select the byte/half lane by off.
  - LB (000) and LH (001) sign-extend. LBU (100) and LHU (101) zero-extend. LW (010, and any other funct3) takes the full word.
  - Fetch: mem_be=4'b1111.
- Captures (on the edge leaving RESP; visible while done=1):
  - Fetch with latched ir_write_en: ir <= mem_rdata. mdr <= mem_rdata as well.
  - Fetch without ir_write_en: only mdr updates.
  - Load: mdr <= extended data; ir unchanged.
  - Store: ir and mdr unchanged.
- mem_gnt in IDLE/RESP/DONE and mem_rvalid outside RESP are ignored.
- Input changes while busy are ignored because all inputs are latched at accept.

Optional Feature:
MEM_ACC_MISALIGN_TRAP_EN.
- Defined: adds output port misalign (1 bit, reset 0). At accept, a misaligned access (half with off[0]=1; word or fetch with off!=0) skips REQ/RESP and goes straight to DONE: no mem_req, ir and mdr unchanged, misalign=1 together with done for that one cycle.
- Not defined: no port. Offset bits below the natural alignment are ignored (half uses off[1] only; word uses neither), and the access proceeds normally.

Test Plan:
- Fetch, pc=0x100, ir_write_en=1, mem_rdata=0x00A00093 with zero-wait gnt, rvalid the next cycle -> mem_addr=0x100, be=1111; done 3 cycles after ce; ir=mdr=0x00A00093.
- LB, alu_result=0x203, rdata=0x80FF_FF7F -> mdr=0xFFFF_FF80. LBU at the same address -> mdr=0x0000_0080.
- SH, alu_result=0x402, store_data=0x1234_ABCD, gnt delayed 3 cycles -> mem_req held 4 cycles with addr=0x400, be=1100, wdata=0xABCD_ABCD; done 1 cycle after gnt.
- Reset asserted in RESP, then mem_rvalid=1 -> mem_req=0, ir=0x13, mdr=0, done never pulses.
- Misaligned LW at 0x301: with the macro -> no mem_req, done=misalign=1 one cycle after the accept edge. Without the macro -> addr=0x300, mdr=rdata.
